delay_event_scheduler: RTL
==========================

Name: delay_event_scheduler

Overview:
- Synthesizable scheduler for delayed events: each accepted request books a timer slot, counts down a per-request cycle delay, then emits a completion event.
- Many requests can be outstanding and overlapping, and several can expire together. A round-robin arbiter serialises the expired slots onto one fire port.
- Sits between a per-cycle trigger source and a single completion consumer. Keeps completion and occupancy counts for status readback.

Parameters:
- NUM_SLOTS, 32, number of concurrent timer slots (>=2)
- DELAY_W, 8, width of requested delay in cycles
- CNT_W, 32, width of the completion counter
- ID_W, $clog2(NUM_SLOTS), slot index width (derived; not overridden)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  new delayed-event request
- req_delay  in  DELAY_W  delay in cycles; 0 treated as 1
- req_ready  out  1  a free slot exists (combinational from slot state)
- req_id  out  ID_W  slot the request will occupy (lowest-index IDLE slot)
- fire_valid  out  1  an expired event is presented
- fire_id  out  ID_W  slot of the presented event
- fire_ready  in  1  consumer accepts event
- done_cnt  out  CNT_W  fire handshakes since reset, wraps modulo 2^CNT_W
- active_cnt  out  ID_W+1  slots not IDLE

Behaviour:
- Reset (async assert, sync-release usage assumed upstream):
  - All slots IDLE, counters 0, RR pointer 0.
  - fire_valid=0, fire_id=0, done_cnt=0, active_cnt=0.
  - req_ready=1, req_id=0.
- Slot FSM: IDLE -> COUNTING on request handshake; COUNTING -> PENDING when remaining count reaches 0; PENDING -> IDLE on fire handshake.
- Timing: a request accepted at edge k with delay D (D=0 -> 1) becomes PENDING at edge k+D. From cycle k+D, fire_valid may be high for that slot. With fire_ready=1 and no contention, the fire handshake lands at edge k+D+1.
- Allocation: the request goes to the lowest-index IDLE slot. If req_valid=1 while req_ready=0, the request is not accepted; the requester holds it.
- Reuse: a slot freed by a fire handshake at edge e is allocatable only from edge e+1 (req_ready reflects registered state, no same-edge reuse).
- Arbitration:
  - Round-robin over PENDING slots, starting at the RR pointer.
  - After each handshake, the pointer moves to fire_id+1, wrapping at NUM_SLOTS.
  - While fire_valid=1 and fire_ready=0, fire_id and fire_valid hold stable.
  - Newly PENDING slots wait their turn; PENDING slots never time out.
- Simultaneous events: a request, an expiry and a fire on different slots on the same edge are all honoured.
- active_cnt: +1 per request handshake, -1 per fire handshake, net 0 when both occur on the same edge. Always equals the count of non-IDLE slots.
- done_cnt: +1 per fire handshake, wraps silently.
- Reset mid-operation: all in-flight and pending events are discarded and no fire is emitted.

Optional Feature:
- Macro: DELAY_SCHED_DROP_CNT_EN.
- Defined:
  - Adds output drop_cnt [CNT_W-1:0], reset 0.
  - A cycle with req_valid=1 and req_ready=0 counts that request as dropped: drop_cnt +1 on that edge, saturating at all-ones.
  - The requester must not retry; req_valid is a per-cycle pulse.
- Not defined: no drop_cnt port; req_valid=1 with req_ready=0 is back-pressure and the request must be held.

Test Plan:
- Reset then idle 50 cycles -> req_ready=1, req_id=0, fire_valid=0, done_cnt=0, active_cnt=0.
- Single request D=5 at edge 10, fire_ready=1 -> fire_valid high in cycle 15 only, fire_id=0, done_cnt=1 after edge 16, active_cnt back to 0.
- Request every cycle, edges 1..100, D=20, fire_ready=1 -> active_cnt peaks at 21, done_cnt=79 after edge 100, no stall.
- 4 requests D=3 on consecutive edges, fire_ready=0 until all are PENDING, then held 1 -> fire_id 0,1,2,3 on consecutive edges with the RR pointer advancing; fire_id stays stable while stalled.
- NUM_SLOTS=4, 6 back-to-back requests D=10 -> req_ready=0 after 4 accepted. Macro undefined: requests 5 and 6 accepted once slots free. Macro defined: drop_cnt=2.
- Assert rst_n mid-run with 3 COUNTING and 1 PENDING slot -> outputs zero immediately, no fire after release, active_cnt=0.

Source files
------------

// File: rtl/delay_event_scheduler.sv
// delay_event_scheduler
// Books a timer slot per accepted request, counts down the requested delay,
// then serialises expired slots onto a single fire port with a round-robin
// arbiter. Completion and occupancy counts are kept for status readback.
//
// Optional build macro: DELAY_SCHED_DROP_CNT_EN
//   When defined, a request presented while no slot is free is dropped and
//   counted in drop_cnt (saturating). When undefined, such a request is
//   back-pressured and the requester holds it.
module delay_event_scheduler #(
    parameter int NUM_SLOTS = 32,
    parameter int DELAY_W   = 8,
    parameter int CNT_W     = 32,
    parameter int ID_W      = $clog2(NUM_SLOTS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    input  logic [DELAY_W-1:0] req_delay,
    output logic               req_ready,
    output logic [ID_W-1:0]    req_id,
    output logic               fire_valid,
    output logic [ID_W-1:0]    fire_id,
    input  logic               fire_ready,
    output logic [CNT_W-1:0]   done_cnt,
    output logic [ID_W:0]      active_cnt
`ifdef DELAY_SCHED_DROP_CNT_EN
    ,
    output logic [CNT_W-1:0]   drop_cnt
`endif
);

    // Per-slot lifecycle: IDLE -> COUNTING -> PENDING -> IDLE
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_COUNT = 2'd1;
    localparam logic [1:0] ST_PEND  = 2'd2;

    logic [1:0]         slot_st  [NUM_SLOTS];
    logic [DELAY_W-1:0] slot_cnt [NUM_SLOTS];

    logic [ID_W-1:0]    rr_ptr;
    logic               hold_vld;
    logic [ID_W-1:0]    hold_id;
    logic               rr_found;
    logic [ID_W-1:0]    rr_pick;
    logic               req_hs;
    logic               fire_hs;

    // A slot loaded with N reaches PENDING N+1 edges later, so the load value
    // is delay-1; a zero delay behaves like a delay of one.
    function automatic logic [DELAY_W-1:0] load_value(input logic [DELAY_W-1:0] d);
        return (d == '0) ? '0 : d - DELAY_W'(1);
    endfunction

`ifdef DELAY_SCHED_DROP_CNT_EN
    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction
`endif

    // Lowest-index IDLE slot is offered to the next request.
    always_comb begin
        req_ready = 1'b0;
        req_id    = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (slot_st[ID_W'(i)] == ST_IDLE) begin
                req_ready = 1'b1;
                req_id    = ID_W'(i);
            end
        end
    end

    // Round-robin search for the first PENDING slot at or after the pointer.
    always_comb begin
        int idx;
        rr_found = 1'b0;
        rr_pick  = '0;
        idx      = 0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_SLOTS) begin
                idx = idx - NUM_SLOTS;
            end
            if (!rr_found && (slot_st[ID_W'(idx)] == ST_PEND)) begin
                rr_found = 1'b1;
                rr_pick  = ID_W'(idx);
            end
        end
    end

    // A stalled offer is frozen so a slot that expires meanwhile cannot
    // displace it; the held slot stays PENDING until its handshake.
    always_comb begin
        fire_valid = rr_found;
        fire_id    = hold_vld ? hold_id : rr_pick;
        req_hs     = req_valid & req_ready;
        fire_hs    = fire_valid & fire_ready;
    end

    // Slot state transitions; request, expiry and fire always touch distinct slots.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slot_st[i] <= ST_IDLE;
            end
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (req_hs && (req_id == ID_W'(i))) begin
                    slot_st[i] <= ST_COUNT;
                end else begin
                    case (slot_st[i])
                        ST_COUNT: begin
                            if (slot_cnt[i] == '0) begin
                                slot_st[i] <= ST_PEND;
                            end
                        end
                        ST_PEND: begin
                            if (fire_hs && (fire_id == ID_W'(i))) begin
                                slot_st[i] <= ST_IDLE;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    // Remaining-delay countdown; only meaningful while the slot is COUNTING.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (req_hs && (req_id == ID_W'(i))) begin
                slot_cnt[i] <= load_value(req_delay);
            end else if ((slot_st[i] == ST_COUNT) && (slot_cnt[i] != '0)) begin
                slot_cnt[i] <= slot_cnt[i] - DELAY_W'(1);
            end
        end
    end

    // Arbiter pointer advance and stall latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr   <= '0;
            hold_vld <= 1'b0;
            hold_id  <= '0;
        end else if (fire_hs) begin
            rr_ptr   <= (fire_id == ID_W'(NUM_SLOTS - 1)) ? '0 : fire_id + ID_W'(1);
            hold_vld <= 1'b0;
        end else if (fire_valid) begin
            hold_vld <= 1'b1;
            hold_id  <= fire_id;
        end
    end

    // Occupancy tracks request/fire handshakes; both on one edge cancel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_cnt <= '0;
        end else begin
            case ({req_hs, fire_hs})
                2'b10:   active_cnt <= active_cnt + (ID_W+1)'(1);
                2'b01:   active_cnt <= active_cnt - (ID_W+1)'(1);
                default: ;
            endcase
        end
    end

    // Completion count, wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_cnt <= '0;
        end else if (fire_hs) begin
            done_cnt <= done_cnt + CNT_W'(1);
        end
    end

`ifdef DELAY_SCHED_DROP_CNT_EN
    // Requests seen with no free slot are lost; count them, saturating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (req_valid && !req_ready) begin
            drop_cnt <= sat_inc(drop_cnt);
        end
    end
`endif

endmodule
